// File: rtl/intc_pkg.sv
// Shared definitions for the interconnect register-bus blocks: FSM state
// encoding and the default register address/data widths.
package intc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_e;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

endpackage

// File: rtl/intc_bs_arb.sv
// Two-master round-robin arbiter onto a single register bus. Each access takes
// two cycles: IDLE captures the winner, ACC drives the bus from registers.
module intc_bs_arb
  import intc_pkg::*;
#(
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req_i,
  input  logic          m0_wr_i,
  input  logic [AW-1:0] m0_addr_i,
  input  logic [DW-1:0] m0_wdata_i,
  output logic          m0_gnt_o,
  output logic          m0_rvld_o,
  output logic [DW-1:0] m0_rdata_o,
  input  logic          m1_req_i,
  input  logic          m1_wr_i,
  input  logic [AW-1:0] m1_addr_i,
  input  logic [DW-1:0] m1_wdata_i,
  output logic          m1_gnt_o,
  output logic          m1_rvld_o,
  output logic [DW-1:0] m1_rdata_o,
  output logic          bs_sel_o,
  output logic          bs_wr_o,
  output logic [AW-1:0] bs_addr_o,
  output logic [DW-1:0] bs_wdata_o,
  input  logic [DW-1:0] rg_rdata_i
);

  state_e        state_q, state_d;
  logic          last_q, last_d;   // 1 = m1 granted last, so m0 wins a tie
  logic          id_q, id_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          rvld0_q, rvld0_d, rvld1_q, rvld1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          win;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    id_d     = id_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    rvld0_d  = 1'b0;
    rvld1_d  = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    win      = m0_req_i ? (m1_req_i ? ~last_q : 1'b0) : 1'b1;

    case (state_q)
      IDLE: begin
        if (m0_req_i || m1_req_i) begin
          state_d = ACC;
          last_d  = win;
          id_d    = win;
          wr_d    = win ? m1_wr_i : m0_wr_i;
          addr_d  = win ? m1_addr_i : m0_addr_i;
          wdata_d = win ? m1_wdata_i : m0_wdata_i;
          gnt0_d  = ~win;
          gnt1_d  = win;
        end
      end
      ACC: begin
        // Requests are not looked at here; the bus sees only captured fields.
        state_d = IDLE;
        if (!wr_q) begin
          if (id_q) begin
            rvld1_d  = 1'b1;
            rdata1_d = rg_rdata_i;
          end else begin
            rvld0_d  = 1'b1;
            rdata0_d = rg_rdata_i;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      last_q   <= 1'b1;
      id_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      rvld0_q  <= 1'b0;
      rvld1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      id_q     <= id_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      rvld0_q  <= rvld0_d;
      rvld1_q  <= rvld1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign bs_sel_o   = (state_q == ACC);
  assign bs_wr_o    = wr_q;
  assign bs_addr_o  = addr_q;
  assign bs_wdata_o = wdata_q;
  assign m0_gnt_o   = gnt0_q;
  assign m1_gnt_o   = gnt1_q;
  assign m0_rvld_o  = rvld0_q;
  assign m1_rvld_o  = rvld1_q;
  assign m0_rdata_o = rdata0_q;
  assign m1_rdata_o = rdata1_q;

endmodule

// File: tb/tb_intc_bs_arb.sv
// Directed bench for intc_bs_arb: lone write/read, pointer behaviour,
// contention, reset mid-access and bus stability during ACC.
module tb_intc_bs_arb;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          m0_req, m0_wr, m1_req, m1_wr;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m0_rvld, m1_gnt, m1_rvld;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          bs_sel, bs_wr;
  logic [AW-1:0] bs_addr;
  logic [DW-1:0] bs_wdata, rg_rdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  intc_bs_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_i(m0_req), .m0_wr_i(m0_wr), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(m0_gnt), .m0_rvld_o(m0_rvld), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_wr_i(m1_wr), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(m1_gnt), .m1_rvld_o(m1_rvld), .m1_rdata_o(m1_rdata),
    .bs_sel_o(bs_sel), .bs_wr_o(bs_wr), .bs_addr_o(bs_addr), .bs_wdata_o(bs_wdata),
    .rg_rdata_i(rg_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".sel"},   64'(bs_sel),   0);
    chk({tag, ".wr"},    64'(bs_wr),    0);
    chk({tag, ".addr"},  64'(bs_addr),  0);
    chk({tag, ".wdata"}, 64'(bs_wdata), 0);
    chk({tag, ".gnt"},   64'({m0_gnt, m1_gnt}),   0);
    chk({tag, ".rvld"},  64'({m0_rvld, m1_rvld}), 0);
    chk({tag, ".rd0"},   64'(m0_rdata), 0);
    chk({tag, ".rd1"},   64'(m1_rdata), 0);
  endtask

  initial begin
    logic [1:0] exp_g;
    rst_n = 1'b0;
    m0_req = 0; m0_wr = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_wr = 0; m1_addr = '0; m1_wdata = '0;
    rg_rdata = '0;
    #12;
    chk_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle.sel", 64'(bs_sel), 0);

    // lone write from m0
    m0_req = 1; m0_wr = 1; m0_addr = 32'h10; m0_wdata = 32'hA5A5A5A5;
    tick();
    chk("wr.sel",   64'(bs_sel),   1);
    chk("wr.wr",    64'(bs_wr),    1);
    chk("wr.addr",  64'(bs_addr),  64'h10);
    chk("wr.wdata", 64'(bs_wdata), 64'hA5A5A5A5);
    chk("wr.gnt",   64'({m0_gnt, m1_gnt}), 64'b10);
    m0_req = 0;
    tick();
    chk("wr.sel2", 64'(bs_sel), 0);
    chk("wr.rvld", 64'({m0_rvld, m1_rvld}), 0);
    chk("wr.gnt2", 64'({m0_gnt, m1_gnt}), 0);

    // lone read from m1; m1_addr changes during ACC must not reach the bus
    m1_req = 1; m1_wr = 0; m1_addr = 32'h04;
    tick();
    rg_rdata = 32'h12345678;
    m1_addr  = 32'h99;
    #1;
    chk("rd.gnt",  64'({m0_gnt, m1_gnt}), 64'b01);
    chk("rd.wr",   64'(bs_wr),   0);
    chk("rd.addr", 64'(bs_addr), 64'h04);
    m1_req = 0;
    tick();
    chk("rd.rvld",  64'({m0_rvld, m1_rvld}), 64'b01);
    chk("rd.rd1",   64'(m1_rdata), 64'h12345678);
    chk("rd.rd0",   64'(m0_rdata), 0);
    chk("rd.sel2",  64'(bs_sel), 0);
    rg_rdata = 32'hDEADBEEF;
    tick();
    chk("rd.rvld2", 64'(m1_rvld), 0);
    chk("rd.hold",  64'(m1_rdata), 64'h12345678);

    // pointer says m0 next anyway, but only m0 asks: granted immediately
    m0_req = 1; m0_wr = 0; m0_addr = 32'h08;
    tick();
    chk("ptr.gnt", 64'({m0_gnt, m1_gnt}), 64'b10);
    rg_rdata = 32'hCAFEF00D;
    m0_req = 0;
    tick();
    chk("ptr.rvld", 64'(m0_rvld), 1);
    chk("ptr.rd0",  64'(m0_rdata), 64'hCAFEF00D);
    chk("ptr.rd1",  64'(m1_rdata), 64'h12345678);

    // after two m0 grants, m1 alone then m0 alone: m1 last, m0 immediate
    m1_req = 1; m1_wr = 1; m1_addr = 32'h50; m1_wdata = 32'h1;
    tick();
    chk("ptr2.gnt1", 64'({m0_gnt, m1_gnt}), 64'b01);
    m1_req = 0;
    m0_req = 1; m0_wr = 1; m0_addr = 32'h54; m0_wdata = 32'h2;
    tick();
    chk("ptr2.idle", 64'(bs_sel), 0);
    tick();
    chk("ptr2.gnt0", 64'({m0_gnt, m1_gnt}), 64'b10);
    chk("ptr2.addr", 64'(bs_addr), 64'h54);
    m0_req = 0;
    tick();

    // contention straight after reset
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    m0_req = 1; m0_wr = 1; m0_addr = 32'h20; m0_wdata = 32'h0;
    m1_req = 1; m1_wr = 1; m1_addr = 32'h30; m1_wdata = 32'h3;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_g = (k % 2 == 0) ? 2'b00 : ((k % 4 == 1) ? 2'b10 : 2'b01);
      chk($sformatf("cont.gnt%0d", k), 64'({m0_gnt, m1_gnt}), 64'(exp_g));
      chk($sformatf("cont.sel%0d", k), 64'(bs_sel), 64'(k % 2));
      if (k % 2 == 1)
        chk($sformatf("cont.addr%0d", k), 64'(bs_addr), (k % 4 == 1) ? 64'h20 : 64'h30);
    end
    m0_req = 0; m1_req = 0;
    tick();

    // reset in the middle of an m0 read
    m0_req = 1; m0_wr = 0; m0_addr = 32'h40;
    rg_rdata = 32'h55AA55AA;
    tick();
    chk("rma.gnt", 64'({m0_gnt, m1_gnt}), 64'b10);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("rma");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m1_req = 1; m1_wr = 1; m1_addr = 32'h60;
    #1;
    chk("rma.rvld0", 64'({m0_rvld, m1_rvld}), 0);
    chk("rma.sel0",  64'(bs_sel), 0);
    tick();
    chk("rma.regnt", 64'({m0_gnt, m1_gnt}), 64'b10);
    chk("rma.rvld1", 64'({m0_rvld, m1_rvld}), 0);
    chk("rma.addr",  64'(bs_addr), 64'h40);
    m0_req = 0;
    tick();
    chk("rma.rvld2", 64'(m0_rvld), 1);
    chk("rma.rd0",   64'(m0_rdata), 64'h55AA55AA);
    tick();
    chk("rma.gnt1",  64'({m0_gnt, m1_gnt}), 64'b01);
    m1_req = 0;
    tick();
    chk("rma.end", 64'({m0_rvld, m1_rvld}), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/intc_bs_arb.md
INTC_BS_ARB -- requirements
Module: intc_bs_arb

Interface
REQ-001 SHALL have parameter AW, default 32, meaning register address width.
REQ-002 SHALL have parameter DW, default 32, meaning register data width.
REQ-003 SHALL have port clk  input  1  single clock; all state rising-edge.
REQ-004 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have ports m0_req_i / m1_req_i  input  1  access request; held with fields stable until matching gnt.
REQ-006 SHALL have ports m0_wr_i / m1_wr_i  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports m0_addr_i / m1_addr_i  input  AW  register address.
REQ-008 SHALL have ports m0_wdata_i / m1_wdata_i  input  DW  write data.
REQ-009 SHALL have ports m0_gnt_o / m1_gnt_o  output  1  one-cycle grant pulse; request accepted.
REQ-010 SHALL have ports m0_rvld_o / m1_rvld_o  output  1  one-cycle read-data-valid pulse.
REQ-011 SHALL have ports m0_rdata_o / m1_rdata_o  output  DW  read data; valid while rvld is high.
REQ-012 SHALL have port bs_sel_o  output  1  register-bus select.
REQ-013 SHALL have port bs_wr_o  output  1  register-bus write strobe qualifier.
REQ-014 SHALL have port bs_addr_o  output  AW  register-bus address.
REQ-015 SHALL have port bs_wdata_o  output  DW  register-bus write data.
REQ-016 SHALL have port rg_rdata_i  input  DW  register read data, valid in the same cycle as bs_sel_o.

Function
REQ-017 SHALL implement FSM IDLE -> ACC -> IDLE; ACC lasts exactly one cycle.
REQ-018 In IDLE with any req high, SHALL register the winner's wr/addr/wdata and winner id, and enter ACC.
REQ-019 In IDLE with no req, SHALL stay in IDLE; bs_sel_o = 0.
REQ-020 In ACC, SHALL drive bs_sel_o = 1 and bs_wr_o/bs_addr_o/bs_wdata_o from the captured fields, all registered (no combinational path from m*_ inputs to bs_*).
REQ-021 In ACC, SHALL assert the winner's gnt_o for exactly that cycle; the loser's gnt_o stays 0.
REQ-022 In ACC, SHALL ignore all req inputs; the requester changes req/fields only after sampling gnt.
REQ-023 For a read in ACC, SHALL capture rg_rdata_i into the winner's rdata_o and pulse the winner's rvld_o in the following cycle; writes produce no rvld.
REQ-024 rdata_o SHALL hold its last value until the next read for that requester.
REQ-025 Arbitration SHALL be round-robin on a 1-bit last-grant pointer, updated on entry to ACC.
REQ-026 With both req high, SHALL grant the requester not granted last; after reset, m0 has priority.
REQ-027 With a single req high, SHALL grant it regardless of the pointer.
REQ-028 Sustained throughput SHALL be one access per 2 cycles; under continuous contention, grants alternate m0, m1, m0, ...
REQ-029 bs_sel_o SHALL be low outside ACC; bs_wr/addr/wdata MAY hold stale values while bs_sel_o = 0.

Reset
REQ-030 Asserting rst_n low SHALL asynchronously force: state IDLE, pointer to m0 priority, and all outputs to 0 (bs_*, gnt, rvld, rdata).
REQ-031 Reset during ACC SHALL abort the access with no gnt or rvld pulse afterward; a requester still holding req is re-arbitrated after release.
REQ-032 After rst_n deassertion, the first grant SHALL occur no earlier than the first rising edge with rst_n high.

Structure
REQ-033 The state enum (IDLE, ACC) and the default AW/DW constants SHALL live in shared package intc_pkg.
REQ-034 The block SHALL be flat with no sub-module; the existing sync-reset flop cell SHALL NOT be used, since reset here is asynchronous.

Verification
REQ-035 Lone write: m0 req wr=1 addr=0x10 wdata=0xA5A5A5A5 -> next cycle bs_sel=1, bs_wr=1, addr 0x10, wdata 0xA5A5A5A5, m0_gnt=1; no rvld.
REQ-036 Lone read: m1 req wr=0 addr=0x04, rg_rdata_i=0x12345678 in ACC -> m1_gnt in ACC; m1_rvld=1 with m1_rdata=0x12345678 one cycle later; m0 outputs unchanged.
REQ-037 Contention after reset: m0 and m1 req together for 8 cycles -> grants m0, m1, m0, m1; bs_sel high every second cycle.
REQ-038 Pointer: m1 granted, then only m0 requests -> m0 granted immediately, no idle gap beyond IDLE.
REQ-039 Reset mid-access: rst_n low during ACC of an m0 read -> all outputs 0 immediately; no rvld after release; pointer returns to m0 priority.
REQ-040 Stability check: change m1_addr while in ACC -> bs_addr_o is unaffected.
